spi_flash_target: RTL and testbench

// SPI mode-0 target emulating a small serial NOR flash: the responder end of the bus driven by
// spi_controller. Decodes READ/PAGE PROGRAM/WREN/WRDI/RDSR from sdi and serves an internal byte

---
 rtl/spi_flash_target.sv | 172 +++++++++++++++++
 tb/tb_spi_flash_target.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_target.sv
// SPI mode-0 serial NOR flash model serving READ / PP / WREN / WRDI / RDSR from an internal byte array.
// All SPI pins are oversampled in the clk domain; edges are taken from the third synchronizer stage.
module spi_flash_target #(
    parameter int DEPTH = 256,
    parameter int PAGE  = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk,
    input  logic cs,
    input  logic sdi,
    output logic sdo,
    output logic sdo_oe,
    output logic wel,
    output logic cmd_done
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PMASK = AW'(PAGE - 1);
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_WREN = 8'h06;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_RDATA, ST_WDATA, ST_STATUS, ST_IGNORE
    } state_t;

    state_t state_q, state_d;

    logic [2:0]    sclk_q, cs_q;
    logic [1:0]    sdi_q;
    logic [2:0]    bit_cnt_q;
    logic [1:0]    byte_cnt_q;
    logic [6:0]    sr_q;
    logic [7:0]    op_q, tx_q;
    logic [AW-1:0] addr_q;
    logic          sdo_q, wel_q, cmd_done_q, cmd_ok_q, extra_q;
    logic [7:0]    mem_q [DEPTH];

    logic          sdi_s, cs_s, cs_fall, cs_rise, bit_in, bit_out;
    logic          shift_in, shift_out, byte_done, mem_we;
    logic [7:0]    rx_byte, src_byte;
    logic [AW-1:0] addr_page_inc;

    assign sdi_s     = sdi_q[1];
    assign cs_s      = cs_q[1];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];
    assign bit_in    = sclk_q[1] & ~sclk_q[2] & ~cs_s;
    assign bit_out   = ~sclk_q[1] & sclk_q[2] & ~cs_s;
    assign shift_in  = bit_in & (state_q inside {ST_CMD, ST_ADDR, ST_WDATA, ST_IGNORE});
    assign shift_out = bit_out & (state_q inside {ST_RDATA, ST_STATUS});
    assign byte_done = shift_in & (bit_cnt_q == 3'd7);
    assign rx_byte   = {sr_q, sdi_s};
    assign mem_we    = byte_done & (state_q == ST_WDATA) & wel_q;
    assign src_byte  = (state_q == ST_STATUS) ? {6'b0, wel_q, 1'b0} : mem_q[addr_q];
    assign addr_page_inc = (addr_q & ~PMASK) | ((addr_q + AW'(1)) & PMASK);

    // cs sync resets low so a cs held low through reset release never looks like a fall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_q <= 3'b000;
            cs_q   <= 3'b000;
            sdi_q  <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            cs_q   <= {cs_q[1:0], cs};
            sdi_q  <= {sdi_q[0], sdi};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cs_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (cs_fall) state_d = ST_CMD;
                ST_CMD: if (byte_done) begin
                    case (rx_byte)
                        OP_READ, OP_PP: state_d = ST_ADDR;
                        OP_RDSR:        state_d = ST_STATUS;
                        default:        state_d = ST_IGNORE;
                    endcase
                end
                ST_ADDR: if (byte_done && byte_cnt_q == 2'd2)
                    state_d = (op_q == OP_READ) ? ST_RDATA : ST_WDATA;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        sdo_oe = 1'b0;
        sdo    = 1'b0;
        if (state_q == ST_RDATA || state_q == ST_STATUS) begin
            sdo_oe = 1'b1;
            sdo    = sdo_q;
        end
    end

    assign wel      = wel_q;
    assign cmd_done = cmd_done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 2'd0;
            sr_q       <= 7'd0;
            op_q       <= 8'd0;
            tx_q       <= 8'd0;
            addr_q     <= '0;
            sdo_q      <= 1'b0;
            wel_q      <= 1'b0;
            cmd_done_q <= 1'b0;
            cmd_ok_q   <= 1'b0;
            extra_q    <= 1'b0;
        end else begin
            cmd_done_q <= cs_rise & cmd_ok_q;
            // op_q is only trusted once the opcode byte of this transaction completed.
            if (cs_rise && cmd_ok_q) begin
                if (op_q == OP_WREN && !extra_q)      wel_q <= 1'b1;
                else if (op_q == OP_WRDI && !extra_q) wel_q <= 1'b0;
                else if (op_q == OP_PP)               wel_q <= 1'b0;
            end
            if (cs_s) begin
                bit_cnt_q  <= 3'd0;
                byte_cnt_q <= 2'd0;
                cmd_ok_q   <= 1'b0;
                extra_q    <= 1'b0;
                sdo_q      <= 1'b0;
            end else begin
                if (shift_in) begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    sr_q      <= rx_byte[6:0];
                    if (state_q == ST_IGNORE) extra_q <= 1'b1;
                    if (state_q == ST_ADDR) begin
                        addr_q <= {addr_q[AW-2:0], sdi_s};
                        if (byte_done) byte_cnt_q <= byte_cnt_q + 2'd1;
                    end
                    if (state_q == ST_CMD && byte_done) begin
                        op_q     <= rx_byte;
                        cmd_ok_q <= 1'b1;
                    end
                    if (state_q == ST_WDATA && byte_done) addr_q <= addr_page_inc;
                end
                if (shift_out) begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd0) begin
                        sdo_q <= src_byte[7];
                        tx_q  <= {src_byte[6:0], 1'b0};
                    end else begin
                        sdo_q <= tx_q[7];
                        tx_q  <= {tx_q[6:0], 1'b0};
                    end
                    if (state_q == ST_RDATA && bit_cnt_q == 3'd7) addr_q <= addr_q + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[addr_q] <= rx_byte;
    end

endmodule

// File: tb/tb_spi_flash_target.sv
// Bench for spi_flash_target: directed flash command sequences plus random traffic,
// checked against a byte-level model of the flash (array, write-enable latch, done count).
module tb_spi_flash_target;
    localparam int DEPTH = 256;
    localparam int PAGE  = 16;
    localparam int HALF  = 4;
    localparam int MAXB  = 264;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic sclk = 1'b0;
    logic cs = 1'b1;
    logic sdi = 1'b0;
    logic sdo, sdo_oe, wel, cmd_done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int m_done = 0;
    logic m_wel = 1'b0;
    logic [7:0] m_mem [DEPTH];

    logic [7:0] tx_buf  [MAXB];
    logic [7:0] rx_buf  [MAXB];
    logic [7:0] exp_buf [MAXB];
    logic       exp_chk [MAXB];
    logic       oe_bits [MAXB*8];
    int         oe_from;

    spi_flash_target #(.DEPTH(DEPTH), .PAGE(PAGE)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs(cs), .sdi(sdi),
        .sdo(sdo), .sdo_oe(sdo_oe), .wel(wel), .cmd_done(cmd_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (cmd_done === 1'b1) done_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic half_bit();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b, output logic so, output logic oe);
        sdi = b;
        half_bit();
        so = sdo;
        oe = sdo_oe;
        sclk = 1'b1;
        half_bit();
        sclk = 1'b0;
    endtask

    task automatic cs_start();
        cs = 1'b0;
        half_bit();
    endtask

    task automatic cs_end();
        half_bit();
        cs = 1'b1;
        repeat (3) half_bit();
    endtask

    task automatic set_hdr(input logic [7:0] op, input int a);
        tx_buf[0] = op;
        tx_buf[1] = 8'(a >> 16);
        tx_buf[2] = 8'(a >> 8);
        tx_buf[3] = 8'(a);
    endtask

    task automatic spi_xfer(input int nbits);
        logic so, oe;
        cs_start();
        for (int i = 0; i < nbits; i++) begin
            spi_bit(tx_buf[i/8][7-(i%8)], so, oe);
            rx_buf[i/8][7-(i%8)] = so;
            oe_bits[i] = oe;
        end
        cs_end();
    endtask

    // Flash behaviour at byte granularity: what the initiator should see and what the array becomes.
    task automatic model_xfer(input int nbits);
        int nb, a;
        logic [7:0] op;
        nb = nbits / 8;
        op = tx_buf[0];
        oe_from = 1 << 30;
        a = int'({tx_buf[1], tx_buf[2], tx_buf[3]}) % DEPTH;
        for (int k = 0; k < MAXB; k++) exp_chk[k] = 1'b0;
        if (nbits < 8) return;
        m_done++;
        case (op)
            8'h06: if (nbits == 8) m_wel = 1'b1;
            8'h04: if (nbits == 8) m_wel = 1'b0;
            8'h05: begin
                oe_from = 8;
                for (int k = 1; k < nb; k++) begin
                    exp_buf[k] = m_wel ? 8'h02 : 8'h00;
                    exp_chk[k] = 1'b1;
                end
            end
            8'h03: begin
                oe_from = 32;
                for (int k = 4; k < nb; k++) begin
                    exp_buf[k] = m_mem[(a + k - 4) % DEPTH];
                    exp_chk[k] = 1'b1;
                end
            end
            8'h02: begin
                if (m_wel)
                    for (int k = 4; k < nb; k++)
                        m_mem[(a / PAGE) * PAGE + (a % PAGE + k - 4) % PAGE] = tx_buf[k];
                m_wel = 1'b0;
            end
            default: ;
        endcase
    endtask

    task automatic run_xfer(input string name, input int nbits);
        int bad;
        model_xfer(nbits);
        spi_xfer(nbits);
        for (int k = 0; k < nbits / 8; k++) begin
            if (exp_chk[k]) begin
                checks++;
                if (rx_buf[k] !== exp_buf[k]) begin
                    errors++;
                    $display("FAIL %s byte%0d sdo: got %02h want %02h", name, k, rx_buf[k], exp_buf[k]);
                end
            end
        end
        bad = -1;
        for (int i = 0; i < nbits; i++)
            if (bad < 0 && oe_bits[i] !== (i >= oe_from)) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s sdo_oe at bit %0d: got %b want %b", name, bad, oe_bits[bad], bad >= oe_from);
        end
        checks++;
        if (wel !== m_wel) begin
            errors++;
            $display("FAIL %s wel: got %b want %b", name, wel, m_wel);
        end
        checks++;
        if (done_cnt !== m_done) begin
            errors++;
            $display("FAIL %s cmd_done count: got %0d want %0d", name, done_cnt, m_done);
        end
        checks++;
        if (sdo !== 1'b0 || sdo_oe !== 1'b0) begin
            errors++;
            $display("FAIL %s idle pins: got sdo=%b oe=%b want 0 0", name, sdo, sdo_oe);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cs = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({sdo, sdo_oe, wel, cmd_done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset outputs: got %b want 0000", {sdo, sdo_oe, wel, cmd_done});
        end
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (wel !== 1'b0 || done_cnt !== 0) begin
            errors++;
            $display("FAIL reset release: got wel=%b done=%0d want 0 0", wel, done_cnt);
        end
    endtask

    task automatic test_wren();
        tx_buf[0] = 8'h06;
        run_xfer("wren", 8);
        checks++;
        if (wel !== 1'b1) begin
            errors++;
            $display("FAIL wren_set: got %b want 1", wel);
        end
        tx_buf[0] = 8'h04;
        run_xfer("wrdi", 8);
        tx_buf[0] = 8'h06;
        run_xfer("wren_9bits", 9);
        checks++;
        if (wel !== 1'b0) begin
            errors++;
            $display("FAIL wren_extra_bit: got %b want 0", wel);
        end
        run_xfer("wren_5bits", 5);
    endtask

    task automatic test_fill();
        for (int p = 0; p < DEPTH / PAGE; p++) begin
            tx_buf[0] = 8'h06;
            run_xfer("fill_wren", 8);
            set_hdr(8'h02, p * PAGE);
            for (int k = 4; k < 4 + PAGE; k++) tx_buf[k] = 8'($urandom);
            run_xfer("fill_pp", 32 + 8 * PAGE);
        end
    endtask

    task automatic test_program_read();
        tx_buf[0] = 8'h06;
        run_xfer("pp_wren", 8);
        set_hdr(8'h02, 24'h000010);
        tx_buf[4] = 8'hAA; tx_buf[5] = 8'hBB; tx_buf[6] = 8'hCC;
        run_xfer("pp_aabbcc", 56);
        set_hdr(8'h03, 24'h000010);
        run_xfer("read_10", 64);
        checks++;
        if ({rx_buf[4], rx_buf[5], rx_buf[6]} !== 24'hAABBCC) begin
            errors++;
            $display("FAIL read_10_const: got %02h%02h%02h want aabbcc", rx_buf[4], rx_buf[5], rx_buf[6]);
        end
    endtask

    task automatic test_no_wren_and_wrap();
        set_hdr(8'h02, 24'h000020);
        tx_buf[4] = 8'h55;
        run_xfer("pp_no_wren", 40);
        set_hdr(8'h03, 24'h000020);
        run_xfer("read_20", 40);
        set_hdr(8'h03, 24'h0000FF);
        run_xfer("read_ff", 48);
        set_hdr(8'h03, 24'h1234FF);
        run_xfer("read_ff_upper", 48);
    endtask

    task automatic test_page_wrap();
        tx_buf[0] = 8'h06;
        run_xfer("wrap_wren", 8);
        set_hdr(8'h02, 24'h00001E);
        tx_buf[4] = 8'h11; tx_buf[5] = 8'h22; tx_buf[6] = 8'h33;
        run_xfer("pp_wrap", 56);
        set_hdr(8'h03, 24'h000010);
        run_xfer("read_page1", 32 + 8 * 16);
        checks++;
        if ({rx_buf[4+14], rx_buf[4+15], rx_buf[4]} !== 24'h112233) begin
            errors++;
            $display("FAIL page_wrap_const: got %02h%02h%02h want 112233", rx_buf[18], rx_buf[19], rx_buf[4]);
        end
    endtask

    task automatic test_rdsr();
        tx_buf[0] = 8'h06;
        run_xfer("rdsr_wren", 8);
        tx_buf[0] = 8'h05;
        run_xfer("rdsr_wel1", 32);
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (rx_buf[k] !== 8'h02) begin
                errors++;
                $display("FAIL rdsr_const byte%0d: got %02h want 02", k, rx_buf[k]);
            end
        end
        tx_buf[0] = 8'h04;
        run_xfer("rdsr_wrdi", 8);
        tx_buf[0] = 8'h05;
        run_xfer("rdsr_wel0", 24);
    endtask

    task automatic test_partial_byte();
        tx_buf[0] = 8'h06;
        run_xfer("part_wren", 8);
        set_hdr(8'h02, 24'h000040);
        tx_buf[4] = 8'h77;
        run_xfer("pp_5bits", 37);
        set_hdr(8'h03, 24'h000040);
        run_xfer("read_40", 40);
    endtask

    task automatic test_reset_abort();
        logic so, oe;
        tx_buf[0] = 8'h06;
        run_xfer("abort_wren", 8);
        set_hdr(8'h02, 24'h000050);
        tx_buf[4] = 8'h99;
        tx_buf[5] = 8'h66;
        cs_start();
        for (int i = 0; i < 43; i++) spi_bit(tx_buf[i/8][7-(i%8)], so, oe);
        reset = 1'b0;
        if (m_wel) m_mem[8'h50] = 8'h99;
        m_wel = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (wel !== 1'b0 || sdo_oe !== 1'b0) begin
            errors++;
            $display("FAIL abort_in_reset: got wel=%b oe=%b want 0 0", wel, sdo_oe);
        end
        reset = 1'b1;
        half_bit();
        tx_buf[0] = 8'h06;
        for (int i = 0; i < 8; i++) spi_bit(tx_buf[0][7-i], so, oe);
        cs_end();
        checks++;
        if (wel !== 1'b0 || done_cnt !== m_done) begin
            errors++;
            $display("FAIL abort_resync: got wel=%b done=%0d want 0 %0d", wel, done_cnt, m_done);
        end
        set_hdr(8'h03, 24'h000050);
        run_xfer("read_50", 40);
        checks++;
        if (rx_buf[4] !== 8'h99) begin
            errors++;
            $display("FAIL abort_kept_byte: got %02h want 99", rx_buf[4]);
        end
    endtask

    task automatic test_random();
        int sel, n, a;
        logic [7:0] op;
        for (int it = 0; it < 24; it++) begin
            sel = int'($urandom_range(0, 5));
            a = int'($urandom_range(0, 24'hFFFFFF));
            n = 8;
            case (sel)
                0: begin
                    set_hdr(8'h03, a);
                    n = 32 + 8 * int'($urandom_range(1, 6));
                end
                1: begin
                    if ($urandom_range(0, 3) != 0) begin
                        tx_buf[0] = 8'h06;
                        run_xfer("rnd_wren", 8);
                    end
                    set_hdr(8'h02, a);
                    for (int k = 4; k < 12; k++) tx_buf[k] = 8'($urandom);
                    n = 32 + 8 * int'($urandom_range(1, 5));
                    if ($urandom_range(0, 2) == 0) n += int'($urandom_range(1, 7));
                end
                2: begin
                    tx_buf[0] = $urandom_range(0, 1) ? 8'h06 : 8'h04;
                    n = 8;
                    if ($urandom_range(0, 2) == 0) n += int'($urandom_range(1, 7));
                end
                3: begin
                    tx_buf[0] = 8'h05;
                    n = 8 + 8 * int'($urandom_range(1, 3));
                end
                4: begin
                    do op = 8'($urandom); while (op inside {[8'h02:8'h06]});
                    set_hdr(op, a);
                    n = int'($urandom_range(8, 24));
                end
                default: begin
                    set_hdr(8'($urandom), a);
                    n = int'($urandom_range(1, 7));
                end
            endcase
            run_xfer("random", n);
        end
    endtask

    task automatic test_readback();
        set_hdr(8'h03, 24'hFF0000);
        run_xfer("readback", 32 + 8 * DEPTH);
    endtask

    initial begin
        test_reset();
        test_wren();
        test_fill();
        test_program_read();
        test_no_wren_and_wrap();
        test_page_wrap();
        test_rdsr();
        test_partial_byte();
        test_reset_abort();
        test_random();
        test_readback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
